// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data ports, bounding fetch starvation
module mem_port_arbiter #(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic [31:0] f_rdata,
  output logic        f_ready,
  input  logic        m_req,
  input  logic        m_write,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic [31:0] m_rdata,
  output logic        m_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_f,
  output logic        stall_m
);
  typedef enum logic [2:0] {IDLE, BUSY_F, BUSY_M, RESP_F, RESP_M} state_t;
  state_t state, nextState;
  logic [3:0] streak;
  logic busy, atLimit, grantM, grantF;
  assign busy = (state == BUSY_F) || (state == BUSY_M);
  assign atLimit = streak == 4'(MAX_DATA_STREAK);
  assign mem_req = busy;
  assign f_ready = state == RESP_F;
  assign m_ready = state == RESP_M;
  assign stall_f = f_req & ~f_ready;
  assign stall_m = m_req & ~m_ready;
  // Grant decision in IDLE (data port wins unless the streak limit is hit) and next-state selection
  always_comb begin
    grantM = (state == IDLE) && m_req && !(f_req && atLimit);
    grantF = (state == IDLE) && f_req && !grantM;
    nextState = grantM ? BUSY_M :
                grantF ? BUSY_F :
                (busy && mem_ack) ? ((state == BUSY_F) ? RESP_F : RESP_M) :
                ((state == RESP_F) || (state == RESP_M)) ? IDLE : state;
  end
  // State, memory command registers, streak counter and captured read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      streak    <= 4'd0;
      mem_write <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      f_rdata   <= 32'h0;
      m_rdata   <= 32'h0;
    end else begin
      state <= nextState;
      if (grantM) begin
        mem_addr  <= m_addr;
        mem_wdata <= m_wdata;
        mem_write <= m_write;
        streak    <= f_req ? (atLimit ? streak : streak + 4'd1) : 4'd0;
      end
      if (grantF) begin
        mem_addr  <= f_addr;
        mem_write <= 1'b0;
        streak    <= 4'd0;
      end
      if (busy && mem_ack) begin
        mem_write <= 1'b0;
        if (state == BUSY_F) f_rdata <= mem_rdata;
        else if (!mem_write) m_rdata <= mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus corner sequences, checked against a grant/response scoreboard
module tb_mem_port_arbiter;
  logic clk, rst;
  logic f_req, f_ready, m_req, m_write, m_ready;
  logic [31:0] f_addr, f_rdata, m_addr, m_wdata, m_rdata;
  logic mem_req, mem_write, mem_ack, stall_f, stall_m;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.MAX_DATA_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_ready(f_ready),
    .m_req(m_req), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata; } grant_t;
  typedef struct { logic isM; logic [31:0] rdata; } resp_t;
  typedef struct {
    logic fr, mr, mw;
    logic [31:0] fa, ma, wd;
    int d;
    logic expFirstM;
    int expLat;
    logic [31:0] expStreak;
  } vec_t;

  grant_t grantQ[$];
  resp_t respQ[$];
  int total = 0, bad = 0;
  int ackDelay = 1;
  logic memEn = 1'b1;
  logic [31:0] lastM = 32'h0;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return (a == 32'h00400000) ? 32'h2008000A : (a ^ 32'h5A5A1234) + 32'd7;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic failNow(input string n);
    total++;
    bad++;
    $display("FAIL %s: got event/timeout expected none", n);
  endtask

  task automatic pushM(input logic [31:0] a, input logic w, input logic [31:0] wd);
    grantQ.push_back('{a, w, wd});
    if (!w) lastM = memData(a);
    respQ.push_back('{1'b1, lastM});
  endtask

  task automatic pushF(input logic [31:0] a);
    grantQ.push_back('{a, 1'b0, 32'h0});
    respQ.push_back('{1'b0, memData(a)});
  endtask

  // memory model: acks once mem_req has been seen for ackDelay+1 falling edges
  initial begin
    int cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'hCCCCCCCC;
    forever begin
      @(negedge clk);
      if (!memEn) cnt = 0;
      else if (mem_ack) begin
        mem_ack = 1'b0;
        mem_rdata = 32'hCCCCCCCC;
        cnt = 0;
      end else if (mem_req) begin
        cnt++;
        if (cnt > ackDelay) begin
          mem_ack = 1'b1;
          mem_rdata = memData(mem_addr);
        end
      end else cnt = 0;
    end
  end

  // monitor: grants, command stability, ready pulses and held read data against the scoreboard
  initial begin
    logic prevReq = 1'b0;
    logic [31:0] modelF = 32'h0, modelM = 32'h0, capAddr = 32'h0, capWdata = 32'h0;
    logic capWr = 1'b0;
    grant_t g;
    resp_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        modelF = 32'h0;
        modelM = 32'h0;
        respQ.delete();
        prevReq = 1'b0;
      end else begin
        if (mem_req && !prevReq) begin
          if (grantQ.size() == 0) failNow("grant_unexpected");
          else begin
            g = grantQ.pop_front();
            chk("grant_addr", mem_addr, g.addr);
            chk("grant_write", {31'h0, mem_write}, {31'h0, g.wr});
            if (g.wr) chk("grant_wdata", mem_wdata, g.wdata);
          end
          capAddr = mem_addr;
          capWdata = mem_wdata;
          capWr = mem_write;
        end else if (mem_req) begin
          chk("busy_addr_stable", mem_addr, capAddr);
          chk("busy_wdata_stable", mem_wdata, capWdata);
          chk("busy_write_stable", {31'h0, mem_write}, {31'h0, capWr});
        end
        if (f_ready || m_ready) begin
          chk("single_ready", {31'h0, f_ready & m_ready}, 32'h0);
          if (respQ.size() == 0) failNow("ready_unexpected");
          else begin
            r = respQ.pop_front();
            chk("ready_port", {31'h0, m_ready}, {31'h0, r.isM});
            if (r.isM) modelM = r.rdata;
            else modelF = r.rdata;
          end
        end
        chk("f_rdata", f_rdata, modelF);
        chk("m_rdata", m_rdata, modelM);
        prevReq = mem_req;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{1, 0, 0, 32'h00400000, 32'h0,        32'h0,        1, 0, 3, 0};
    vecs[1] = '{0, 1, 0, 32'h0,        32'h7FF00010, 32'h0,        1, 1, 3, 0};
    vecs[2] = '{1, 1, 0, 32'h00400004, 32'h7FF00010, 32'h0,        1, 1, 3, 1};
    vecs[3] = '{0, 1, 1, 32'h0,        32'h7FF00020, 32'hDEADBEEF, 5, 1, 7, 0};
    vecs[4] = '{1, 0, 0, 32'h00400008, 32'h0,        32'h0,        2, 0, 4, 0};
    vecs[5] = '{1, 1, 1, 32'h0040000C, 32'h10000000, 32'h0BADF00D, 3, 1, 5, 1};
    rst = 1'b1; f_req = 0; m_req = 0; m_write = 0;
    f_addr = 0; m_addr = 0; m_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'h0, mem_req}, 0);
    chk("rst_mem_write", {31'h0, mem_write}, 0);
    chk("rst_f_ready", {31'h0, f_ready}, 0);
    chk("rst_m_ready", {31'h0, m_ready}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_f_rdata", f_rdata, 0);
    chk("rst_m_rdata", m_rdata, 0);
    chk("rst_streak", 32'(dut.streak), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      int cyc = 0;
      logic firstSeen = 0, fDone, mDone;
      ackDelay = vecs[i].d;
      if (vecs[i].mr) pushM(vecs[i].ma, vecs[i].mw, vecs[i].wd);
      if (vecs[i].fr) pushF(vecs[i].fa);
      f_addr = vecs[i].fa; m_addr = vecs[i].ma; m_write = vecs[i].mw; m_wdata = vecs[i].wd;
      f_req = vecs[i].fr; m_req = vecs[i].mr;
      fDone = !vecs[i].fr; mDone = !vecs[i].mr;
      while (!(fDone && mDone) && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
        if (f_req) chk($sformatf("v%0d_stall_f", i), {31'h0, stall_f}, {31'h0, ~f_ready});
        if (m_req) chk($sformatf("v%0d_stall_m", i), {31'h0, stall_m}, {31'h0, ~m_ready});
        if (!firstSeen && (f_ready || m_ready)) begin
          firstSeen = 1;
          chk($sformatf("v%0d_latency", i), cyc, vecs[i].expLat);
          chk($sformatf("v%0d_first_is_m", i), {31'h0, m_ready}, {31'h0, vecs[i].expFirstM});
          chk($sformatf("v%0d_streak", i), 32'(dut.streak), vecs[i].expStreak);
        end
        if (f_ready) begin f_req = 0; fDone = 1; end
        if (m_ready) begin m_req = 0; mDone = 1; end
      end
      if (!(fDone && mDone)) failNow($sformatf("v%0d_timeout", i));
      @(posedge clk); #1;
      chk($sformatf("v%0d_streak_end", i), 32'(dut.streak), 0);
    end

    begin : starvation
      int cyc = 0, mCnt = 0;
      logic fDone = 0;
      ackDelay = 1;
      for (int k = 0; k < 4; k++) pushM(32'h7FF00100 + 32'(4 * k), 0, 0);
      pushF(32'h00400100);
      pushM(32'h7FF00110, 0, 0);
      f_addr = 32'h00400100; m_addr = 32'h7FF00100; m_write = 0;
      f_req = 1; m_req = 1;
      while (!(fDone && mCnt == 5) && cyc < 100) begin
        @(posedge clk); #1;
        cyc++;
        if (f_ready) begin
          chk("starve_m_grants_before_f", mCnt, 4);
          chk("starve_streak_after_f", 32'(dut.streak), 0);
          f_req = 0; fDone = 1;
        end
        if (m_ready) begin
          if (!fDone) chk("starve_streak_up", 32'(dut.streak), 32'(mCnt + 1));
          mCnt++;
          if (mCnt == 5) m_req = 0;
          else m_addr = 32'h7FF00100 + 32'(4 * mCnt);
        end
      end
      if (!(fDone && mCnt == 5)) failNow("starve_timeout");
      @(posedge clk); #1;
    end

    begin : drop
      int cyc = 0;
      logic seen = 0;
      ackDelay = 3;
      pushF(32'h00400200);
      f_addr = 32'h00400200; f_req = 1;
      @(posedge clk); #1;
      chk("drop_busy", {31'h0, mem_req}, 1);
      f_req = 0;
      while (!seen && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
        if (f_ready) seen = 1;
      end
      chk("drop_ready_seen", {31'h0, seen}, 1);
      @(posedge clk); #1;
    end

    begin : midreset
      memEn = 0;
      mem_ack = 0;
      grantQ.push_back('{32'h7FF00300, 1'b0, 32'h0});
      m_addr = 32'h7FF00300; m_write = 0; m_req = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_busy", {31'h0, mem_req}, 1);
      rst = 1;
      @(posedge clk); #1;
      rst = 0; m_req = 0;
      mem_ack = 1; mem_rdata = 32'h12345678;
      chk("mid_mem_req", {31'h0, mem_req}, 0);
      chk("mid_m_ready", {31'h0, m_ready}, 0);
      chk("mid_mem_addr", mem_addr, 0);
      chk("mid_mem_wdata", mem_wdata, 0);
      chk("mid_mem_write", {31'h0, mem_write}, 0);
      chk("mid_f_rdata", f_rdata, 0);
      chk("mid_m_rdata", m_rdata, 0);
      chk("mid_state_idle", 32'(dut.state), 0);
      @(posedge clk); #1;
      mem_ack = 0;
      chk("late_ack_mem_req", {31'h0, mem_req}, 0);
      chk("late_ack_m_ready", {31'h0, m_ready}, 0);
      chk("late_ack_m_rdata", m_rdata, 0);
      chk("late_ack_state_idle", 32'(dut.state), 0);
      memEn = 1;
      repeat (2) @(posedge clk);
      #1;
    end

    chk("grant_queue_empty", grantQ.size(), 0);
    chk("resp_queue_empty", respQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: MAX_DATA_STREAK, default 4, max consecutive data-port grants while fetch waits (range 1-15).
REQ-002 Clock and reset: one clock, clk; reset rst, synchronous, active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 f_req  input  1  fetch read request, held until f_ready.
REQ-006 f_addr  input  32  fetch word address, stable while f_req high.
REQ-007 f_rdata  output  32  fetch read data, valid while f_ready high.
REQ-008 f_ready  output  1  one-cycle fetch completion pulse.
REQ-009 m_req  input  1  data-port request, held until m_ready.
REQ-010 m_write  input  1  1 = store, 0 = load; stable while m_req high.
REQ-011 m_addr  input  32  data-port address.
REQ-012 m_wdata  input  32  store data.
REQ-013 m_rdata  output  32  load data, valid while m_ready high.
REQ-014 m_ready  output  1  one-cycle data-port completion pulse.
REQ-015 mem_req  output  1  request to the shared single-port memory.
REQ-016 mem_write  output  1  store strobe to memory.
REQ-017 mem_addr  output  32  memory address.
REQ-018 mem_wdata  output  32  memory write data.
REQ-019 mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-020 mem_ack  input  1  memory completion, any latency of 1 cycle or more after mem_req rises.
REQ-021 stall_f  output  1  fetch-stage stall for the hazard unit.
REQ-022 stall_m  output  1  memory-stage stall for the hazard unit.

Function
REQ-023 The FSM SHALL use the states IDLE, BUSY_F, BUSY_M, RESP_F and RESP_M.
REQ-024 IDLE transitions, evaluated at the clock edge:
- m_req only: go to BUSY_M.
- f_req only: go to BUSY_F.
- Both set: go to BUSY_M unless streak == MAX_DATA_STREAK, in which case go to BUSY_F.
- Neither set: stay in IDLE.
REQ-025 On entering BUSY_x, mem_req SHALL be 1 and the mem_addr, mem_write and mem_wdata registers SHALL be loaded from port x; for fetch, mem_write = 0.
REQ-026 The mem_* outputs SHALL stay constant in BUSY_x until the edge on which mem_ack = 1.
REQ-027 On the mem_ack edge: go to RESP_x, drive mem_req = 0, and register mem_rdata into x_rdata, except that m_rdata SHALL NOT change for a store.
REQ-028 RESP_x SHALL assert x_ready for exactly one cycle, ignore all requests and return to IDLE.
REQ-029 Minimum latency from req sampled in IDLE to x_ready SHALL be 3 cycles when mem_ack arrives 1 cycle after mem_req.
REQ-030 mem_ack outside BUSY_F or BUSY_M SHALL be ignored.
REQ-031 The streak counter SHALL be 4 bits wide and updated at grant time as follows:
- M granted with f_req = 1: increment, saturating at MAX_DATA_STREAK.
- M granted with f_req = 0: clear to 0.
- F granted: clear to 0.
REQ-032 stall_f = f_req & ~f_ready and stall_m = m_req & ~m_ready, both combinational.
REQ-033 f_rdata and m_rdata SHALL hold their last values between completions.
REQ-034 A requester dropping req while in BUSY_x SHALL NOT abort the memory transaction; x_ready still pulses.

Reset
REQ-035 In any cycle with rst = 1, the next state SHALL be IDLE.
REQ-036 On reset, streak SHALL be 0.
REQ-037 On reset, mem_req, mem_write, f_ready and m_ready SHALL be 0.
REQ-038 On reset, mem_addr, mem_wdata, f_rdata and m_rdata SHALL be 32'h0.
REQ-039 Reset during BUSY_x SHALL drop mem_req on the next edge with no x_ready pulse, and any later mem_ack SHALL be ignored.
REQ-040 rst SHALL take priority over every concurrent request and mem_ack.

Verification
REQ-041 Lone fetch: f_req with f_addr=32'h00400000, mem_ack 1 cycle after mem_req, mem_rdata=32'h2008000A -> mem_addr=32'h00400000 with mem_write=0, f_rdata=32'h2008000A, f_ready one cycle 3 cycles after request; stall_f high until then.
REQ-042 Collision: f_req and m_req (load, m_addr=32'h7FF00010) in the same IDLE cycle -> data port served first (m_ready), fetch next; streak 1 then 0.
REQ-043 Starvation: f_req held while m_req reasserted after every m_ready, MAX_DATA_STREAK=4 -> exactly 4 M grants, then an F grant, streak back to 0.
REQ-044 Store: m_write=1, m_wdata=32'hDEADBEEF, mem_ack after 5 cycles -> mem_wdata stable for all 5 cycles, m_ready pulses, m_rdata unchanged.
REQ-045 Reset mid-transaction: rst in the 2nd BUSY_M cycle, then mem_ack -> mem_req=0 next edge, no m_ready, all outputs at reset values, FSM in IDLE.
REQ-046 Requester drop: f_req deasserted in BUSY_F -> transaction completes and the f_ready pulse still occurs.
